// File: rtl/pifo_ring_pkg.sv
// Shared types and constants for the PIFO ring issue controller.
// - Widths derived from payload/metadata widths, ring size and tree count.
// - slot_t : ring token {valid, hops remaining}.
// - resp_t : pop response entry {tree, root RPU, empty flag}.
// - root_of(): the RPU that holds the root of a tree.
package pifo_ring_pkg;

  localparam int PTW       = 16;
  localparam int MTW       = 0;
  localparam int DW        = MTW + PTW;
  localparam int LEVEL     = 4;
  localparam int TREE_NUM  = 4;
  localparam int STAGE_CYC = 2;
  localparam int POP_LAT   = 2;
  localparam int CNTW      = LEVEL;

  localparam int TIDW = $clog2(TREE_NUM);
  localparam int RW   = $clog2(LEVEL);
  localparam int HW   = $clog2(LEVEL + 1);
  localparam int PHW  = (STAGE_CYC > 1) ? $clog2(STAGE_CYC) : 1;

  // Tree capacity: a full binary tree of LEVEL levels.
  localparam logic [CNTW-1:0] CAP = {CNTW{1'b1}};

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_e;

  typedef struct packed {
    logic          valid;
    logic [HW-1:0] hops;
  } slot_t;

  typedef struct packed {
    logic [TIDW-1:0] tree;
    logic [RW-1:0]   rpu;
    logic            empty;
  } resp_t;

  // LEVEL and TREE_NUM are powers of two, so "mod LEVEL" is a bit slice.
  function automatic logic [RW-1:0] root_of(input logic [TIDW-1:0] tree);
    return tree[RW-1:0];
  endfunction

endpackage

// File: rtl/pifo_ring_issue_ctrl_if.sv
// Request / ring-injection / response bundle of the PIFO ring issue controller.
// - master : requester plus ring side (drives requests and per-RPU pop data).
// - slave  : the issue controller.
interface pifo_ring_issue_ctrl_if;
  import pifo_ring_pkg::*;

  logic                     i_req_valid;
  logic                     o_req_ready;
  logic                     i_req_pop;
  logic [TIDW-1:0]          i_req_tree_id;
  logic [DW-1:0]            i_req_data;
  logic                     o_push;
  logic                     o_pop;
  logic [TIDW-1:0]          o_tree_id;
  logic [DW-1:0]            o_push_data;
  logic [LEVEL*DW-1:0]      i_rpu_pop_data;
  logic                     o_pop_valid;
  logic [TIDW-1:0]          o_pop_tree_id;
  logic [DW-1:0]            o_pop_data;
  logic                     o_pop_empty;
  logic                     o_push_drop;
  logic [TREE_NUM*CNTW-1:0] o_occupancy;

  modport master (
    output i_req_valid, i_req_pop, i_req_tree_id, i_req_data, i_rpu_pop_data,
    input  o_req_ready, o_push, o_pop, o_tree_id, o_push_data,
           o_pop_valid, o_pop_tree_id, o_pop_data, o_pop_empty, o_push_drop, o_occupancy
  );

  modport slave (
    input  i_req_valid, i_req_pop, i_req_tree_id, i_req_data, i_rpu_pop_data,
    output o_req_ready, o_push, o_pop, o_tree_id, o_push_data,
           o_pop_valid, o_pop_tree_id, o_pop_data, o_pop_empty, o_push_drop, o_occupancy
  );

endinterface

// File: rtl/pifo_ring_slot_tracker.sv
// Tracks which ring RPU each in-flight op occupies in the current epoch.
// Ports:
// - i_clk, i_arst_n : clock, async active-low reset
// - load, load_rpu  : place a fresh token (hops=LEVEL) at load_rpu
// - query_rpu       : RPU whose occupancy is asked about
// - phase_zero      : current cycle is the first of an epoch
// - query_free      : no token sits at query_rpu
module pifo_ring_slot_tracker
  import pifo_ring_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_arst_n,
  input  logic          load,
  input  logic [RW-1:0] load_rpu,
  input  logic [RW-1:0] query_rpu,
  output logic          phase_zero,
  output logic          query_free
);

  logic [PHW-1:0] phase_r;
  logic           boundary_s;
  slot_t          slot_r     [LEVEL];
  slot_t          slot_nxt_s [LEVEL];

  assign boundary_s = (phase_r == PHW'(STAGE_CYC - 1));
  assign phase_zero = (phase_r == {PHW{1'b0}});
  assign query_free = !slot_r[query_rpu].valid;

  // Epoch phase counter, wraps after STAGE_CYC cycles.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      phase_r <= {PHW{1'b0}};
    end else if (boundary_s) begin
      phase_r <= {PHW{1'b0}};
    end else begin
      phase_r <= phase_r + PHW'(1);
    end
  end

  // Next slot contents: a fresh load wins; otherwise tokens hop one RPU per
  // epoch and retire after their last hop. Computed per destination slot.
  always_comb begin
    for (int d = 0; d < LEVEL; d++) begin
      if (load && (load_rpu == RW'(d))) begin
        slot_nxt_s[d] = '{valid: 1'b1, hops: HW'(LEVEL)};
      end else if (boundary_s) begin
        if (slot_r[(d + LEVEL - 1) % LEVEL].valid &&
            (slot_r[(d + LEVEL - 1) % LEVEL].hops > HW'(1))) begin
          slot_nxt_s[d] = '{valid: 1'b1,
                            hops:  slot_r[(d + LEVEL - 1) % LEVEL].hops - HW'(1)};
        end else begin
          slot_nxt_s[d] = '{valid: 1'b0, hops: {HW{1'b0}}};
        end
      end else begin
        slot_nxt_s[d] = slot_r[d];
      end
    end
  end

  // Slot array register.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int j = 0; j < LEVEL; j++) begin
        slot_r[j] <= '{valid: 1'b0, hops: {HW{1'b0}}};
      end
    end else begin
      slot_r <= slot_nxt_s;
    end
  end

endmodule

// File: rtl/pifo_ring_issue_ctrl.sv
// Issue controller in front of the multi-tree PIFO SRAM ring.
// Ports:
// - i_clk, i_arst_n : clock, async active-low reset
// - bus (slave)     : request valid/ready, registered ring injection strobes,
//                     per-RPU pop data in, registered pop responses,
//                     push-drop pulse and per-tree occupancy.
// Pushes to a full tree are consumed and dropped; pops to an empty tree are
// answered with all-ones data and the empty flag, at the normal latency.
module pifo_ring_issue_ctrl
  import pifo_ring_pkg::*;
(
  input logic                   i_clk,
  input logic                   i_arst_n,
  pifo_ring_issue_ctrl_if.slave bus
);

  logic [RW-1:0]   root_s;
  logic            phase_zero_s;
  logic            root_free_s;
  logic            ready_s;
  logic            accept_s;
  op_e             op_s;
  logic [CNTW-1:0] cnt_sel_s;
  logic            full_s;
  logic            empty_s;
  logic            push_ok_s;
  logic            pop_ok_s;
  logic            drop_s;
  logic            pop_acc_s;

  logic [CNTW-1:0] cnt_r [TREE_NUM];
  logic            push_r;
  logic            pop_r;
  logic            drop_r;
  logic [TIDW-1:0] tree_id_r;
  logic [DW-1:0]   push_data_r;

  logic            issue_vld_r;
  resp_t           issue_r;
  logic            pipe_vld_r [POP_LAT];
  resp_t           pipe_r     [POP_LAT];
  resp_t           tail_s;
  logic [DW-1:0]   tail_word_s;
  logic            pop_valid_r;
  logic            pop_empty_r;
  logic [TIDW-1:0] pop_tree_r;
  logic [DW-1:0]   pop_data_r;

  assign root_s = root_of(bus.i_req_tree_id);

  pifo_ring_slot_tracker u_slots (
    .i_clk      (i_clk),
    .i_arst_n   (i_arst_n),
    .load       (push_ok_s | pop_ok_s),
    .load_rpu   (root_s),
    .query_rpu  (root_s),
    .phase_zero (phase_zero_s),
    .query_free (root_free_s)
  );

  // Handshake and op decode; only real injections claim a ring slot.
  always_comb begin
    ready_s   = i_arst_n & phase_zero_s & root_free_s;
    accept_s  = bus.i_req_valid & ready_s;
    op_s      = bus.i_req_pop ? OP_POP : OP_PUSH;
    cnt_sel_s = cnt_r[bus.i_req_tree_id];
    full_s    = (cnt_sel_s == CAP);
    empty_s   = (cnt_sel_s == {CNTW{1'b0}});
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    drop_s    = 1'b0;
    pop_acc_s = 1'b0;
    if (accept_s) begin
      case (op_s)
        OP_PUSH: begin
          push_ok_s = !full_s;
          drop_s    = full_s;
        end
        OP_POP: begin
          pop_ok_s  = !empty_s;
          pop_acc_s = 1'b1;
        end
        default: begin
          push_ok_s = 1'b0;
          pop_ok_s  = 1'b0;
        end
      endcase
    end else begin
      pop_acc_s = 1'b0;
    end
  end

  // Per-tree occupancy counters; saturation is guaranteed by the decode above.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int t = 0; t < TREE_NUM; t++) begin
        cnt_r[t] <= {CNTW{1'b0}};
      end
    end else if (push_ok_s) begin
      cnt_r[bus.i_req_tree_id] <= cnt_sel_s + CNTW'(1);
    end else if (pop_ok_s) begin
      cnt_r[bus.i_req_tree_id] <= cnt_sel_s - CNTW'(1);
    end
  end

  // Ring injection strobes; tree id and data are zero outside the strobe cycle.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      push_r      <= 1'b0;
      pop_r       <= 1'b0;
      drop_r      <= 1'b0;
      tree_id_r   <= {TIDW{1'b0}};
      push_data_r <= {DW{1'b0}};
    end else begin
      push_r      <= push_ok_s;
      pop_r       <= pop_ok_s;
      drop_r      <= drop_s;
      tree_id_r   <= (push_ok_s | pop_ok_s) ? bus.i_req_tree_id : {TIDW{1'b0}};
      push_data_r <= push_ok_s ? bus.i_req_data : {DW{1'b0}};
    end
  end

  // Response pipe: the issue stage lines up with the strobe, so the tail sees
  // the ring data POP_LAT cycles after injection.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      issue_vld_r <= 1'b0;
      issue_r     <= '{tree: {TIDW{1'b0}}, rpu: {RW{1'b0}}, empty: 1'b0};
      for (int k = 0; k < POP_LAT; k++) begin
        pipe_vld_r[k] <= 1'b0;
        pipe_r[k]     <= '{tree: {TIDW{1'b0}}, rpu: {RW{1'b0}}, empty: 1'b0};
      end
    end else begin
      issue_vld_r   <= pop_acc_s;
      issue_r       <= '{tree: bus.i_req_tree_id, rpu: root_s, empty: empty_s};
      pipe_vld_r[0] <= issue_vld_r;
      pipe_r[0]     <= issue_r;
      for (int k = 1; k < POP_LAT; k++) begin
        pipe_vld_r[k] <= pipe_vld_r[k-1];
        pipe_r[k]     <= pipe_r[k-1];
      end
    end
  end

  assign tail_s      = pipe_r[POP_LAT-1];
  assign tail_word_s = bus.i_rpu_pop_data[tail_s.rpu*DW +: DW];

  // Registered response outputs, all zero when no response is due.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      pop_valid_r <= 1'b0;
      pop_empty_r <= 1'b0;
      pop_tree_r  <= {TIDW{1'b0}};
      pop_data_r  <= {DW{1'b0}};
    end else if (pipe_vld_r[POP_LAT-1]) begin
      pop_valid_r <= 1'b1;
      pop_empty_r <= tail_s.empty;
      pop_tree_r  <= tail_s.tree;
      pop_data_r  <= tail_s.empty ? {DW{1'b1}} : tail_word_s;
    end else begin
      pop_valid_r <= 1'b0;
      pop_empty_r <= 1'b0;
      pop_tree_r  <= {TIDW{1'b0}};
      pop_data_r  <= {DW{1'b0}};
    end
  end

  // Drive the bundle outputs.
  always_comb begin
    bus.o_req_ready   = ready_s;
    bus.o_push        = push_r;
    bus.o_pop         = pop_r;
    bus.o_tree_id     = tree_id_r;
    bus.o_push_data   = push_data_r;
    bus.o_push_drop   = drop_r;
    bus.o_pop_valid   = pop_valid_r;
    bus.o_pop_tree_id = pop_tree_r;
    bus.o_pop_data    = pop_data_r;
    bus.o_pop_empty   = pop_empty_r;
    for (int t = 0; t < TREE_NUM; t++) begin
      bus.o_occupancy[t*CNTW +: CNTW] = cnt_r[t];
    end
  end

endmodule

// File: tb/tb_pifo_ring_issue_ctrl.sv
// Randomised bench for pifo_ring_issue_ctrl with an epoch-level reference model
// (tokens are tracked by injection epoch and root, not by slot contents).
module tb_pifo_ring_issue_ctrl;
  import pifo_ring_pkg::*;

  localparam int CAPI = (1 << LEVEL) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  pifo_ring_issue_ctrl_if bus ();

  pifo_ring_issue_ctrl dut (
    .i_clk    (clk),
    .i_arst_n (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int epoch; int root; } tok_t;
  typedef struct { int due; int tree; int rpu; bit empty; } rsp_t;

  tok_t toks[$];
  rsp_t rsps[$];
  int cnt [TREE_NUM];
  logic [LEVEL*DW-1:0] hist [8];
  int n = 0;
  bit e_push, e_pop, e_drop;
  int e_tree, e_data;
  // model scratch, used only by the model process
  int ep, r, t, k;
  bit busy, rdy, ev, eemp;
  int etree;
  logic [DW-1:0] edata;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", bus.o_req_ready, 0);
      chk("rst_push", bus.o_push, 0);
      chk("rst_pop", bus.o_pop, 0);
      chk("rst_tree", bus.o_tree_id, 0);
      chk("rst_pdata", bus.o_push_data, 0);
      chk("rst_drop", bus.o_push_drop, 0);
      chk("rst_pvalid", bus.o_pop_valid, 0);
      chk("rst_ptree", bus.o_pop_tree_id, 0);
      chk("rst_pempty", bus.o_pop_empty, 0);
      chk("rst_popdata", bus.o_pop_data, 0);
      chk("rst_occ", bus.o_occupancy, 0);
      toks.delete();
      rsps.delete();
      for (int i = 0; i < TREE_NUM; i++) cnt[i] = 0;
      n = 0; e_push = 0; e_pop = 0; e_drop = 0; e_tree = 0; e_data = 0;
    end else begin
      chk("push", bus.o_push, e_push);
      chk("pop", bus.o_pop, e_pop);
      chk("drop", bus.o_push_drop, e_drop);
      chk("tree_id", bus.o_tree_id, e_tree);
      chk("push_data", bus.o_push_data, e_data);
      for (int i = 0; i < TREE_NUM; i++)
        chk("occupancy", bus.o_occupancy[i*CNTW +: CNTW], cnt[i]);
      ev = 0; eemp = 0; etree = 0; edata = '0;
      for (int i = 0; i < rsps.size(); i++) begin
        if (rsps[i].due == n) begin
          ev = 1; eemp = rsps[i].empty; etree = rsps[i].tree;
          edata = rsps[i].empty ? {DW{1'b1}} : hist[(n-1)%8][rsps[i].rpu*DW +: DW];
          rsps.delete(i);
          break;
        end
      end
      chk("pop_valid", bus.o_pop_valid, ev);
      chk("pop_empty", bus.o_pop_empty, eemp);
      chk("pop_tree", bus.o_pop_tree_id, etree);
      chk("pop_data", bus.o_pop_data, edata);
      hist[n%8] = bus.i_rpu_pop_data;
      // a token injected in epoch E at root R sits at (R+k)%LEVEL in epoch E+k, k<LEVEL
      ep = n / STAGE_CYC;
      r  = int'(bus.i_req_tree_id) % LEVEL;
      while (toks.size() > 0 && ep - toks[0].epoch >= LEVEL) void'(toks.pop_front());
      busy = 0;
      foreach (toks[i]) begin
        k = ep - toks[i].epoch;
        if (k >= 1 && (toks[i].root + k) % LEVEL == r) busy = 1;
      end
      rdy = (n % STAGE_CYC == 0) && !busy;
      chk("ready", bus.o_req_ready, rdy);
      e_push = 0; e_pop = 0; e_drop = 0; e_tree = 0; e_data = 0;
      if (bus.i_req_valid && rdy) begin
        t = int'(bus.i_req_tree_id);
        if (!bus.i_req_pop) begin
          if (cnt[t] < CAPI) begin
            e_push = 1; e_tree = t; e_data = int'(bus.i_req_data);
            cnt[t]++;
            toks.push_back('{ep, r});
          end else begin
            e_drop = 1;
          end
        end else begin
          rsps.push_back('{n + POP_LAT + 2, t, r, cnt[t] == 0});
          if (cnt[t] > 0) begin
            e_pop = 1; e_tree = t;
            cnt[t]--;
            toks.push_back('{ep, r});
          end
        end
      end
      n++;
    end
  end

  // ---------------- stimulus ----------------
  logic [LEVEL*DW-1:0] rpu_w;
  initial begin
    bus.i_rpu_pop_data = '0;
    forever begin
      @(posedge clk); #1;
      for (int j = 0; j < LEVEL; j++) rpu_w[j*DW +: DW] = DW'($urandom);
      bus.i_rpu_pop_data = rpu_w;
    end
  end

  task automatic do_req(input bit pop, input int tree, input int data);
    bit ok = 0;
    int w = 0;
    @(posedge clk); #1;
    bus.i_req_valid = 1'b1;
    bus.i_req_pop = pop;
    bus.i_req_tree_id = TIDW'(tree);
    bus.i_req_data = DW'(data);
    while (!ok && w < 20) begin
      @(negedge clk);
      if (bus.o_req_ready) ok = 1;
      @(posedge clk); #1;
      w++;
    end
    bus.i_req_valid = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL accept_timeout: tree %0d not accepted within 20 cycles", tree);
    end
  endtask

  task automatic rand_cycles(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
      bus.i_req_valid = ($urandom_range(0, 9) < 7);
      bus.i_req_pop = ($urandom_range(0, 9) < 4);
      bus.i_req_tree_id = TIDW'($urandom_range(0, TREE_NUM - 1));
      bus.i_req_data = DW'($urandom);
    end
    bus.i_req_valid = 1'b0;
  endtask

  logic [DW-1:0] cap_w;

  initial begin
    bus.i_req_valid = 1'b0;
    bus.i_req_pop = 1'b0;
    bus.i_req_tree_id = '0;
    bus.i_req_data = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // push 5 to tree0: one strobe, occupancy 1
    do_req(1'b0, 0, 5);
    @(negedge clk);
    chk("t1_push", bus.o_push, 1);
    chk("t1_tree", bus.o_tree_id, 0);
    chk("t1_data", bus.o_push_data, 16'h0005);
    chk("t1_occ0", bus.o_occupancy[0 +: CNTW], 1);

    // next epoch: token now sits at RPU1, so tree1 blocked, tree0 free
    @(posedge clk); #1;
    bus.i_req_tree_id = 2'd1;
    @(negedge clk);
    chk("t4_rpu1_blocked", bus.o_req_ready, 0);
    #1 bus.i_req_tree_id = 2'd0;
    #1 chk("t4_rpu0_free", bus.o_req_ready, 1);

    // fill tree1 to capacity, then one more is dropped
    for (int i = 0; i < 15; i++) do_req(1'b0, 1, 100 + i);
    do_req(1'b0, 1, 999);
    @(negedge clk);
    chk("t2_drop", bus.o_push_drop, 1);
    chk("t2_no_push", bus.o_push, 0);
    chk("t2_occ1", bus.o_occupancy[CNTW +: CNTW], 15);

    // pop of empty tree2
    do_req(1'b1, 2, 0);
    @(negedge clk);
    chk("t3_no_pop", bus.o_pop, 0);
    repeat (POP_LAT + 1) @(negedge clk);
    chk("t3_valid", bus.o_pop_valid, 1);
    chk("t3_empty", bus.o_pop_empty, 1);
    chk("t3_data", bus.o_pop_data, 16'hFFFF);
    chk("t3_tree", bus.o_pop_tree_id, 2);

    // push 3 then pop tree0: data is RPU0 ring data POP_LAT cycles after strobe
    do_req(1'b0, 0, 3);
    do_req(1'b1, 0, 0);
    @(negedge clk);
    chk("t5_pop", bus.o_pop, 1);
    repeat (POP_LAT) @(negedge clk);
    cap_w = bus.i_rpu_pop_data[0 +: DW];
    @(negedge clk);
    chk("t5_valid", bus.o_pop_valid, 1);
    chk("t5_empty", bus.o_pop_empty, 0);
    chk("t5_data", bus.o_pop_data, cap_w);
    do_req(1'b1, 0, 0);
    @(negedge clk);
    chk("t5_occ0", bus.o_occupancy[0 +: CNTW], 0);

    rand_cycles(3000);

    // reset with ops in flight
    repeat (6) begin
      @(posedge clk); #1;
      bus.i_req_valid = 1'b1;
      bus.i_req_pop = $urandom_range(0, 1);
      bus.i_req_tree_id = TIDW'($urandom_range(0, TREE_NUM - 1));
      bus.i_req_data = DW'($urandom);
    end
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    rand_cycles(500);
    repeat (10) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
